// File: rtl/instruction_fetch_control.sv
// instruction_fetch_control
//   Program-counter and fetch-sequencing stage in front of a combinational
//   instruction memory. It captures each fetched word into an IF/ID register
//   and hands it to decode through a valid/ready handshake.
//
//   It handles stall, redirect with flush, HALT detection and
//   out-of-range fetch faults.
//
// Ports
//   clk             in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   imem_addr       out  word address to instruction memory (= pc)
//   imem_instr      in   instruction returned for imem_addr (same cycle)
//   redirect_valid  in   branch/jump taken this cycle
//   redirect_target in   new pc when redirect_valid=1
//   id_ready        in   decode accepts the IF/ID register this cycle
//   if_valid        out  IF/ID register holds a valid instruction
//   if_instr        out  registered instruction
//   if_pc           out  pc of if_instr
//   halted          out  fetch stopped on HALT
//   fetch_fault     out  fetch stopped on an out-of-range pc
module instruction_fetch_control #(
  parameter int unsigned       ADDR_W      = 72,
  parameter int unsigned       INSTR_W     = 72,
  parameter int unsigned       IMEM_DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [5:0]        HALT_OPCODE = 6'b111111
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               halted,
  output logic               fetch_fault
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(IMEM_DEPTH);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_if_valid;
  logic [INSTR_W-1:0]  r_if_instr;
  logic [ADDR_W-1:0]  r_if_pc;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic                w_if_valid_nxt;
  logic                w_capture;
  logic                w_load_ok;
  logic                w_out_of_range;
  logic                w_is_halt;

  assign w_load_ok      = !r_if_valid || id_ready;
  assign w_out_of_range = (r_pc >= LP_DEPTH);
  assign w_is_halt      = (imem_instr[INSTR_W-1 -: 6] == HALT_OPCODE);

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_valid_nxt = r_if_valid;
    w_capture      = 1'b0;
    case (r_state)
      ST_RUN: begin
        // Redirect flushes regardless of id_ready and masks HALT/fault.
        if (redirect_valid) begin
          w_pc_nxt       = redirect_target;
          w_if_valid_nxt = 1'b0;
        end else if (w_out_of_range && w_load_ok) begin
          w_state_nxt    = ST_FAULT;
          w_if_valid_nxt = 1'b0;
        end else if (w_load_ok) begin
          w_capture      = 1'b1;
          w_if_valid_nxt = 1'b1;
          w_pc_nxt       = r_pc + ADDR_W'(1);
          if (w_is_halt) begin
            w_state_nxt = ST_HALTED;
          end
        end
      end
      ST_HALTED, ST_FAULT: begin
        if (redirect_valid) begin
          w_pc_nxt       = redirect_target;
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = ST_RUN;
        end else if (r_if_valid && id_ready) begin
          w_if_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
      if (w_capture) begin
        r_if_instr <= imem_instr;
        r_if_pc    <= r_pc;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign halted      = (r_state == ST_HALTED);
  assign fetch_fault = (r_state == ST_FAULT);

endmodule

// File: tb/tb_instruction_fetch_control.sv
// tb_instruction_fetch_control
//   Directed-vector bench for instruction_fetch_control. A behavioural
//   instruction memory answers combinationally. Word 5 carries the HALT
//   opcode, and every other word is a fixed tag ORed with its address.
module tb_instruction_fetch_control;

  localparam int unsigned AW = 72;
  localparam int unsigned IW = 72;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_instr;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic          id_ready;
  logic          if_valid;
  logic [IW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          halted;
  logic          fetch_fault;

  int unsigned total;
  int unsigned bad;

  instruction_fetch_control #(
    .ADDR_W     (AW),
    .INSTR_W    (IW),
    .IMEM_DEPTH (1024),
    .RESET_PC   ('0),
    .HALT_OPCODE(6'b111111)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .halted         (halted),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
    if (a == 72'd5) return {6'b111111, 66'h5};
    return {6'h0A, 2'b00, 64'hC0DE_0000_0000_0000 | a[63:0]};
  endfunction

  assign imem_instr = word(imem_addr);

  task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks a freshly captured fetch of word p.
  task automatic expect_fetch(input string tag, input logic [AW-1:0] p);
    chk({tag, ".valid"}, IW'(if_valid), IW'(1));
    chk({tag, ".instr"}, if_instr, word(p));
    chk({tag, ".pc"},    IW'(if_pc), IW'(p));
    chk({tag, ".addr"},  IW'(imem_addr), IW'(p + 72'd1));
  endtask

  task automatic redirect_to(input logic [AW-1:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    step();
    redirect_valid  = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    id_ready = 1'b1;

    #12;
    chk("rst.valid", IW'(if_valid), IW'(0));
    chk("rst.instr", if_instr, '0);
    chk("rst.pc",    IW'(if_pc), IW'(0));
    chk("rst.addr",  IW'(imem_addr), IW'(0));
    chk("rst.halt",  IW'(halted), IW'(0));
    chk("rst.fault", IW'(fetch_fault), IW'(0));
    reset_n = 1'b1;

    // Sequential fetch of words 0 and 1.
    step(); expect_fetch("seq0", 72'd0);
    step(); expect_fetch("seq1", 72'd1);

    // Stall for three cycles while B is held.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_fetch("stall", 72'd1);
    end
    id_ready = 1'b1;
    step(); expect_fetch("seq2", 72'd2);
    step(); expect_fetch("seq3", 72'd3);

    // Redirect while stalled flushes the held instruction.
    id_ready = 1'b0;
    redirect_to(72'd100);
    chk("redir.valid", IW'(if_valid), IW'(0));
    chk("redir.addr",  IW'(imem_addr), IW'(100));
    id_ready = 1'b1;
    step(); expect_fetch("redir.f", 72'd100);

    // HALT at word 5.
    redirect_to(72'd4);
    chk("r4.valid", IW'(if_valid), IW'(0));
    step(); expect_fetch("w4", 72'd4);
    chk("w4.halt", IW'(halted), IW'(0));
    step(); expect_fetch("halt", 72'd5);
    chk("halt.flag", IW'(halted), IW'(1));
    id_ready = 1'b0;
    step(); expect_fetch("halt.hold", 72'd5);
    chk("halt.hold.flag", IW'(halted), IW'(1));
    id_ready = 1'b1;
    step();
    chk("drain.valid", IW'(if_valid), IW'(0));
    chk("drain.addr",  IW'(imem_addr), IW'(6));
    chk("drain.halt",  IW'(halted), IW'(1));
    step();
    chk("idle.valid", IW'(if_valid), IW'(0));
    chk("idle.addr",  IW'(imem_addr), IW'(6));
    redirect_to(72'd0);
    chk("resume.halt",  IW'(halted), IW'(0));
    chk("resume.valid", IW'(if_valid), IW'(0));
    chk("resume.addr",  IW'(imem_addr), IW'(0));
    step(); expect_fetch("resume.f", 72'd0);

    // Redirect in the same cycle HALT is presented discards it.
    redirect_to(72'd5);
    chk("rh.addr", IW'(imem_addr), IW'(5));
    redirect_to(72'd20);
    chk("rh.halt",  IW'(halted), IW'(0));
    chk("rh.valid", IW'(if_valid), IW'(0));
    chk("rh.addr2", IW'(imem_addr), IW'(20));
    step(); expect_fetch("rh.f", 72'd20);
    chk("rh.halt2", IW'(halted), IW'(0));

    // Last valid word fetches, the next pc faults.
    redirect_to(72'd1023);
    step(); expect_fetch("last", 72'd1023);
    chk("last.fault", IW'(fetch_fault), IW'(0));
    step();
    chk("fault.flag",  IW'(fetch_fault), IW'(1));
    chk("fault.valid", IW'(if_valid), IW'(0));
    chk("fault.addr",  IW'(imem_addr), IW'(1024));
    step();
    chk("fault.hold",  IW'(imem_addr), IW'(1024));
    chk("fault.flag2", IW'(fetch_fault), IW'(1));
    redirect_to(72'd10);
    chk("clr.fault", IW'(fetch_fault), IW'(0));
    chk("clr.addr",  IW'(imem_addr), IW'(10));
    step(); expect_fetch("clr.f", 72'd10);

    // Out-of-range redirect target faults on the following edge.
    redirect_to(72'h8000_0000_0000_0000_00);
    chk("oor.fault0", IW'(fetch_fault), IW'(0));
    step();
    chk("oor.fault1", IW'(fetch_fault), IW'(1));
    redirect_to(72'd2);
    step(); expect_fetch("oor.f", 72'd2);

    // Asynchronous reset mid-stall.
    id_ready = 1'b0;
    step(); expect_fetch("pre.rst", 72'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.valid", IW'(if_valid), IW'(0));
    chk("arst.instr", if_instr, '0);
    chk("arst.pc",    IW'(if_pc), IW'(0));
    chk("arst.addr",  IW'(imem_addr), IW'(0));
    chk("arst.halt",  IW'(halted), IW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
